// File: rtl/alu_mul_seq.sv
// Multi-cycle 16x16 unsigned shift-and-add multiplier that borrows the datapath ALU.
// Produces the low 16 product bits plus overflow and zero flags behind a start/busy/done handshake.
module alu_mul_seq #(
    parameter bit EARLY_EXIT = 1'b1,
    parameter int ITER_MAX   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] op_a,
    input  logic [15:0] op_b,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        ovf,
    output logic        zero,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [4:0]  alu_f,
    output logic        alu_fsel,
    output logic        alu_csel,
    output logic        alu_ucin,
    input  logic [15:0] alu_y,
    input  logic        alu_cout
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_SHIFT,
        S_DONE
    } state_t;

    localparam logic [4:0] F_PASS_A = 5'b00000;
    localparam logic [4:0] F_ADD    = 5'b10010;
    localparam logic [4:0] F_SHL    = 5'b00001;

    state_t      r_state;
    logic [15:0] r_acc;
    logic [15:0] r_mcand;
    logic [15:0] r_mplr;
    logic [4:0]  r_cnt;
    logic        r_ovfAcc;
    logic        r_busy;
    logic        r_done;
    logic [15:0] r_result;
    logic        r_ovf;
    logic        r_zero;

    logic [15:0] w_mplrNext;
    logic        w_shiftOvf;
    logic        w_lastIter;
    logic        w_finish;

    // A multiplicand bit shifted out is only lost product if multiplier bits remain to use it.
    assign w_mplrNext = r_mplr >> 1;
    assign w_shiftOvf = r_mcand[15] && (w_mplrNext != 16'd0);
    assign w_lastIter = (r_cnt == 5'(ITER_MAX - 1));
    assign w_finish   = w_lastIter || (EARLY_EXIT && (w_mplrNext == 16'd0));

    always_comb begin
        alu_a    = 16'd0;
        alu_b    = 16'd0;
        alu_f    = F_PASS_A;
        alu_fsel = 1'b0;
        case (r_state)
            S_ADD: begin
                alu_a = r_acc;
                alu_b = r_mcand;
                alu_f = F_ADD;
            end
            S_SHIFT: begin
                alu_a    = r_mcand;
                alu_b    = 16'd1;
                alu_f    = F_SHL;
                alu_fsel = 1'b1;
            end
            default: ;
        endcase
    end

    assign alu_csel = 1'b0;
    assign alu_ucin = 1'b0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_acc    <= 16'd0;
            r_mcand  <= 16'd0;
            r_mplr   <= 16'd0;
            r_cnt    <= 5'd0;
            r_ovfAcc <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= 16'd0;
            r_ovf    <= 1'b0;
            r_zero   <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_acc    <= 16'd0;
                        r_mcand  <= op_a;
                        r_mplr   <= op_b;
                        r_cnt    <= 5'd0;
                        r_ovfAcc <= 1'b0;
                        r_busy   <= 1'b1;
                        if (EARLY_EXIT && (op_b == 16'd0)) begin
                            r_state  <= S_DONE;
                            r_done   <= 1'b1;
                            r_result <= 16'd0;
                            r_ovf    <= 1'b0;
                            r_zero   <= 1'b1;
                        end else if (op_b[0]) begin
                            r_state <= S_ADD;
                        end else begin
                            r_state <= S_SHIFT;
                        end
                    end
                end
                S_ADD: begin
                    r_acc    <= alu_y;
                    r_ovfAcc <= r_ovfAcc | alu_cout;
                    r_state  <= S_SHIFT;
                end
                S_SHIFT: begin
                    r_mcand  <= alu_y;
                    r_mplr   <= w_mplrNext;
                    r_cnt    <= r_cnt + 5'd1;
                    r_ovfAcc <= r_ovfAcc | w_shiftOvf;
                    // The accumulator is final here since SHIFT never touches it.
                    if (w_finish) begin
                        r_state  <= S_DONE;
                        r_done   <= 1'b1;
                        r_result <= r_acc;
                        r_ovf    <= r_ovfAcc | w_shiftOvf;
                        r_zero   <= (r_acc == 16'd0);
                    end else if (r_mplr[1]) begin
                        r_state <= S_ADD;
                    end else begin
                        r_state <= S_SHIFT;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;
    assign ovf    = r_ovf;
    assign zero   = r_zero;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq: one instance per EARLY_EXIT setting, each wired to a behavioural ALU,
// checked cycle by cycle against a reference built from plain multiplication and bit counting.
module tb_alu_mul_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] op_a;
    logic [15:0] op_b;

    logic        busy1, done1, ovf1, zero1, aluFsel1, aluCsel1, aluUcin1, aluCout1;
    logic [15:0] result1, aluA1, aluB1, aluY1;
    logic [4:0]  aluF1;
    logic        busy0, done0, ovf0, zero0, aluFsel0, aluCsel0, aluUcin0, aluCout0;
    logic [15:0] result0, aluA0, aluB0, aluY0;
    logic [4:0]  aluF0;

    int totalChecks = 0;
    int badChecks   = 0;

    localparam logic [5:0] CODE_PASS  = 6'b0_00000;
    localparam logic [5:0] CODE_ADD   = 6'b0_10010;
    localparam logic [5:0] CODE_SHIFT = 6'b1_00001;

    alu_mul_seq #(.EARLY_EXIT(1'b1), .ITER_MAX(16)) dutEarly (
        .clk(clk), .reset(reset), .start(start), .op_a(op_a), .op_b(op_b),
        .busy(busy1), .done(done1), .result(result1), .ovf(ovf1), .zero(zero1),
        .alu_a(aluA1), .alu_b(aluB1), .alu_f(aluF1), .alu_fsel(aluFsel1),
        .alu_csel(aluCsel1), .alu_ucin(aluUcin1), .alu_y(aluY1), .alu_cout(aluCout1)
    );

    alu_mul_seq #(.EARLY_EXIT(1'b0), .ITER_MAX(16)) dutFull (
        .clk(clk), .reset(reset), .start(start), .op_a(op_a), .op_b(op_b),
        .busy(busy0), .done(done0), .result(result0), .ovf(ovf0), .zero(zero0),
        .alu_a(aluA0), .alu_b(aluB0), .alu_f(aluF0), .alu_fsel(aluFsel0),
        .alu_csel(aluCsel0), .alu_ucin(aluUcin0), .alu_y(aluY0), .alu_cout(aluCout0)
    );

    always #5 clk = ~clk;

    // Combinational datapath ALU: pass A, 16-bit add with carry, and left shift.
    function automatic logic [16:0] aluModel(input logic [15:0] a, input logic [15:0] b,
                                             input logic [4:0] f, input logic fsel);
        if (fsel) return {1'b0, a << b[3:0]};
        if (f == 5'b10010) return {1'b0, a} + {1'b0, b};
        return {1'b0, a};
    endfunction

    always_comb {aluCout1, aluY1} = aluModel(aluA1, aluB1, aluF1, aluFsel1);
    always_comb {aluCout0, aluY0} = aluModel(aluA0, aluB0, aluF0, aluFsel0);

    // Multiplier bits consumed: up to the top set bit with early exit, all 16 otherwise.
    function automatic int expectedIters(input logic [15:0] b, input bit ee);
        int n = 0;
        if (!ee) return 16;
        for (int i = 0; i < 16; i++) if (b[i]) n = i + 1;
        return n;
    endfunction

    function automatic int expectedDone(input logic [15:0] b, input bit ee);
        int n   = expectedIters(b, ee);
        int cyc = 1 + n;
        for (int i = 0; i < n; i++) if (b[i]) cyc++;
        return cyc;
    endfunction

    function automatic logic [5:0] expectedCode(input logic [15:0] b, input bit ee, input int k);
        int n   = expectedIters(b, ee);
        int pos = 1;
        for (int i = 0; i < n; i++) begin
            if (b[i]) begin
                if (pos == k) return CODE_ADD;
                pos++;
            end
            if (pos == k) return CODE_SHIFT;
            pos++;
        end
        return CODE_PASS;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkCycle(input string name, input bit ee, input logic [15:0] a, input logic [15:0] b,
                              input int k, input logic busyV, input logic doneV, input logic [5:0] codeV,
                              input logic [15:0] resV, input logic ovfV, input logic zeroV);
        int          exp  = expectedDone(b, ee);
        logic [31:0] prod = 32'(a) * 32'(b);
        checkOutput({name, ".done"}, 32'(doneV), 32'(k == exp));
        checkOutput({name, ".busy"}, 32'(busyV), 32'(k <= exp));
        checkOutput({name, ".aluop"}, 32'(codeV), 32'(expectedCode(b, ee, k)));
        if (k >= exp) begin
            checkOutput({name, ".result"}, 32'(resV), 32'(prod[15:0]));
            checkOutput({name, ".ovf"}, 32'(ovfV), 32'(prod[31:16] != 16'd0));
            checkOutput({name, ".zero"}, 32'(zeroV), 32'(prod[15:0] == 16'd0));
        end
    endtask

    // Starts one multiply on both instances and follows them for a fixed window of cycles.
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b);
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 36; k++) begin
            checkCycle("early", 1'b1, a, b, k, busy1, done1, {aluFsel1, aluF1}, result1, ovf1, zero1);
            checkCycle("full", 1'b0, a, b, k, busy0, done0, {aluFsel0, aluF0}, result0, ovf0, zero0);
            @(negedge clk);
        end
    endtask

    initial begin
        bit sawDone;
        reset = 1'b1;
        start = 1'b0;
        op_a  = 16'd0;
        op_b  = 16'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        checkOutput("reset.busy", 32'(busy1), 32'd0);
        checkOutput("reset.done", 32'(done1), 32'd0);
        checkOutput("reset.result", 32'(result1), 32'd0);
        checkOutput("reset.ovf", 32'(ovf1), 32'd0);
        checkOutput("reset.zero", 32'(zero1), 32'd1);
        checkOutput("reset.alu", {aluA1, aluB1}, 32'd0);
        checkOutput("reset.aluop", 32'({aluFsel1, aluF1}), 32'(CODE_PASS));
        checkOutput("reset.carry", 32'({aluCsel1, aluUcin1, aluCsel0, aluUcin0}), 32'd0);
        checkOutput("reset.full", 32'({busy0, done0, ovf0, zero0}), 32'b0001);

        applyStimulus(16'd5, 16'd3);
        applyStimulus(16'h1234, 16'h0000);
        applyStimulus(16'hFFFF, 16'hFFFF);
        applyStimulus(16'h0100, 16'h0100);
        applyStimulus(16'h8000, 16'h0002);
        applyStimulus(16'h0000, 16'h8001);

        for (int n = 0; n < 36; n++) begin
            logic [15:0] a = 16'($urandom);
            logic [15:0] b;
            case ($urandom_range(0, 3))
                0:       b = 16'($urandom_range(0, 15));
                1:       b = 16'($urandom_range(0, 255));
                default: b = 16'($urandom);
            endcase
            if ($urandom_range(0, 1) == 1) a = 16'($urandom_range(0, 255));
            applyStimulus(a, b);
        end

        // A second start while busy must be ignored; the next one lands right after done.
        op_a  = 16'd5;
        op_b  = 16'd3;
        start = 1'b1;
        @(negedge clk);
        for (int k = 1; k <= 5; k++) begin
            if (k == 2) begin
                op_a  = 16'd9;
                op_b  = 16'd9;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            checkOutput("busyStart.done", 32'(done1), 32'(k == 5));
            @(negedge clk);
        end
        checkOutput("busyStart.result", 32'(result1), 32'd15);
        checkOutput("busyStart.idle", 32'({busy1, done1}), 32'b00);
        op_a  = 16'd9;
        op_b  = 16'd9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            checkOutput("backToBack.done", 32'(done1), 32'(k == 7));
            if (k == 7) checkOutput("backToBack.result", 32'(result1), 32'd81);
            @(negedge clk);
        end
        for (int k = 0; k < 40 && busy0; k++) @(negedge clk);
        checkOutput("busyStart.fullIdle", 32'(busy0), 32'd0);
        checkOutput("busyStart.fullResult", 32'(result0), 32'd15);

        // Reset during the third cycle of a long multiply aborts it without a done pulse.
        op_a  = 16'hFFFF;
        op_b  = 16'hFFFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        checkOutput("midReset.busy", 32'({busy1, busy0}), 32'd0);
        checkOutput("midReset.result", {result1, result0}, 32'd0);
        checkOutput("midReset.flags", 32'({ovf1, zero1, ovf0, zero0}), 32'b0101);
        sawDone = 1'b0;
        for (int k = 0; k < 36; k++) begin
            if (done1 || done0 || busy1 || busy0) sawDone = 1'b1;
            @(negedge clk);
        end
        checkOutput("midReset.quiet", 32'(sawDone), 32'd0);
        applyStimulus(16'd7, 16'd6);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
